// File: rtl/seq_chunk_adder.sv
// ============================================================================
// Module   : seq_chunk_adder
// Brief    : Multi-cycle WIDTH-bit adder, CHUNK bits per clock with a carry
//            register between slices. Optional macro SEQ_ADD_OVF_EN adds an
//            ovf output carrying the two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_IDXW   = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NCHUNK - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic              r_carry;
  logic [c_IDXW-1:0] r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;

  logic [CHUNK:0]    w_slice;
  logic [WIDTH-1:0]  w_acc_next;
  logic              w_last;

  assign w_slice = {1'b0, r_a[r_idx*CHUNK +: CHUNK]}
                 + {1'b0, r_b[r_idx*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_idx == c_LAST_IDX);

  // Accumulator with the current slice merged in, so the final slice is
  // visible in the same edge that loads sum.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_next = c_RUN;
      c_RUN:   if (w_last) w_state_next = c_DONE;
      c_DONE:  w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != c_IDLE);
    done = (r_state == c_DONE);
  end

`ifdef SEQ_ADD_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // a^b^s at the MSB recovers the carry into the MSB.
  assign w_ovf = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_acc_next[WIDTH-1] ^ w_slice[CHUNK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_ovf <= 1'b0;
    else if (r_state == c_RUN && w_last) r_ovf <= w_ovf;
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_acc   <= '0;
            r_idx   <= '0;
          end
        end
        c_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice[CHUNK];
          if (w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_slice[CHUNK];
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench: 16-bit/4-bit-chunk instance plus an 8-bit
// single-chunk instance; ovf checks appear when SEQ_ADD_OVF_EN is defined.
`default_nettype none

module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

`ifdef SEQ_ADD_OVF_EN
  logic        ovf16, ovf8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf16)
`endif
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  // Issues one request on u_dut16; returns the number of edges after the
  // accepting edge until done is seen (-1 on timeout) and how many cycles of
  // the operation showed busy low. Operands are scrambled right after accept.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                      output int edges, output int busy_low);
    @(posedge clk); #1;
    a16 = ta; b16 = tb_; cin16 = tc; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = ~ta; b16 = ~tb_; cin16 = ~tc;
    edges = -1; busy_low = 0;
    for (int n = 1; n <= 20; n++) begin
      if (!busy16) busy_low++;
      @(posedge clk); #1;
      if (done16) begin
        if (!busy16) busy_low++;
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done16: got %b expected 0", done16); end
    n_checks++; if (sum16 !== 16'h0000) begin n_fail++; $display("FAIL reset_sum16: got %h expected 0000", sum16); end
    n_checks++; if (cout16 !== 1'b0) begin n_fail++; $display("FAIL reset_cout16: got %b expected 0", cout16); end
    n_checks++; if ({busy8, done8, sum8, cout8} !== 11'd0) begin n_fail++; $display("FAIL reset_dut8: got %b expected 0", {busy8, done8, sum8, cout8}); end
`ifdef SEQ_ADD_OVF_EN
    n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf16: got %b expected 0", ovf16); end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int e, bl;
    op16(16'h00FF, 16'h0001, 1'b0, e, bl);
    // done is seen after edge k+NCHUNK; busy spans the 4 RUN cycles plus DONE.
    n_checks++; if (e !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", e); end
    n_checks++; if (bl !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d low cycles expected 0", bl); end
    n_checks++; if (sum16 !== 16'h0100) begin n_fail++; $display("FAIL basic_sum: got %h expected 0100", sum16); end
    n_checks++; if (cout16 !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b expected 0", cout16); end
`ifdef SEQ_ADD_OVF_EN
    n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", ovf16); end
`endif
    @(posedge clk); #1;
    n_checks++; if ({busy16, done16} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got %b expected 00", {busy16, done16}); end
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (sum16 !== 16'h0100) begin n_fail++; $display("FAIL basic_hold: got %h expected 0100", sum16); end
  endtask

  task automatic test_full_carry;
    int e, bl;
    op16(16'hFFFF, 16'h0000, 1'b1, e, bl);
    n_checks++; if (e !== 4) begin n_fail++; $display("FAIL carry_latency: got %0d expected 4", e); end
    n_checks++; if ({cout16, sum16} !== 17'h1_0000) begin n_fail++; $display("FAIL carry_result: got %h expected 10000", {cout16, sum16}); end
`ifdef SEQ_ADD_OVF_EN
    n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL carry_ovf: got %b expected 0", ovf16); end
`endif
    op16(16'hA5A5, 16'h5A5A, 1'b0, e, bl);
    n_checks++; if ({cout16, sum16} !== 17'h0_FFFF) begin n_fail++; $display("FAIL alt_nocin: got %h expected 0FFFF", {cout16, sum16}); end
    op16(16'hA5A5, 16'h5A5A, 1'b1, e, bl);
    n_checks++; if ({cout16, sum16} !== 17'h1_0000) begin n_fail++; $display("FAIL alt_cin: got %h expected 10000", {cout16, sum16}); end
  endtask

  task automatic test_overflow;
    int e, bl;
    op16(16'h7FFF, 16'h0001, 1'b0, e, bl);
    n_checks++; if ({cout16, sum16} !== 17'h0_8000) begin n_fail++; $display("FAIL ovf_pos_result: got %h expected 08000", {cout16, sum16}); end
`ifdef SEQ_ADD_OVF_EN
    n_checks++; if (ovf16 !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag: got %b expected 1", ovf16); end
`endif
    op16(16'h8000, 16'h8000, 1'b0, e, bl);
    n_checks++; if ({cout16, sum16} !== 17'h1_0000) begin n_fail++; $display("FAIL ovf_neg_result: got %h expected 10000", {cout16, sum16}); end
`ifdef SEQ_ADD_OVF_EN
    n_checks++; if (ovf16 !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_flag: got %b expected 1", ovf16); end
`endif
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    logic [16:0] got = '0;
    @(posedge clk); #1;
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (done16) begin dones++; got = {cout16, sum16}; end
      @(posedge clk); #1;
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    n_checks++; if (got !== 17'h0_2345) begin n_fail++; $display("FAIL ignore_result: got %h expected 02345", got); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued: got busy %b expected 0", busy16); end
  endtask

  task automatic test_reset_mid;
    int e, bl;
    int dones = 0;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++; if ({busy16, done16} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 00", {busy16, done16}); end
    n_checks++; if ({cout16, sum16} !== 17'h0_0000) begin n_fail++; $display("FAIL rstmid_result: got %h expected 00000", {cout16, sum16}); end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (n == 2) rst = 1'b0;
      if (done16) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones); end
    op16(16'h0003, 16'h0004, 1'b0, e, bl);
    n_checks++; if (e !== 4) begin n_fail++; $display("FAIL rstmid_relatency: got %0d expected 4", e); end
    n_checks++; if ({cout16, sum16} !== 17'h0_0007) begin n_fail++; $display("FAIL rstmid_reresult: got %h expected 00007", {cout16, sum16}); end
  endtask

  task automatic test_single_chunk;
    int e = -1;
    @(posedge clk); #1;
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done8) begin e = n; break; end
    end
    n_checks++; if (e !== 1) begin n_fail++; $display("FAIL chunk8_latency: got %0d expected 1", e); end
    n_checks++; if ({cout8, sum8} !== 9'h12D) begin n_fail++; $display("FAIL chunk8_result: got %h expected 12d", {cout8, sum8}); end
`ifdef SEQ_ADD_OVF_EN
    n_checks++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL chunk8_ovf: got %b expected 0", ovf8); end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_carry;
    test_overflow;
    test_busy_ignore;
    test_reset_mid;
    test_single_chunk;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
